// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 encodings and FSM state types for the burst memory responder.
//   - BURST_* : AxBURST encodings
//   - RESP_*  : xRESP encodings
//   - wr_state_t / rd_state_t : write and read channel FSM states
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// -----------------------------------------------------------------------------
// axi_burst_mem_slave_if
// AXI4 bus bundle (AW, W, B, AR, R channels) between a master and the
// burst memory responder.
//   modport slave  : responder side (drives READY on AW/W/AR, VALID on B/R)
//   modport master : requester side
// Parameters: ADDR_W address width, DATA_W data width, ID_W ID width.
// -----------------------------------------------------------------------------
interface axi_burst_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) ();

    // write address
    logic [ID_W-1:0]     S_AWID;
    logic [ADDR_W-1:0]   S_AWADDR;
    logic [7:0]          S_AWLEN;
    logic [2:0]          S_AWSIZE;
    logic [1:0]          S_AWBURST;
    logic                S_AWVALID;
    logic                S_AWREADY;
    // write data
    logic [DATA_W-1:0]   S_WDATA;
    logic [DATA_W/8-1:0] S_WSTRB;
    logic                S_WLAST;
    logic                S_WVALID;
    logic                S_WREADY;
    // write response
    logic [ID_W-1:0]     S_BID;
    logic [1:0]          S_BRESP;
    logic                S_BVALID;
    logic                S_BREADY;
    // read address
    logic [ID_W-1:0]     S_ARID;
    logic [ADDR_W-1:0]   S_ARADDR;
    logic [7:0]          S_ARLEN;
    logic [2:0]          S_ARSIZE;
    logic [1:0]          S_ARBURST;
    logic                S_ARVALID;
    logic                S_ARREADY;
    // read data
    logic [ID_W-1:0]     S_RID;
    logic [DATA_W-1:0]   S_RDATA;
    logic [1:0]          S_RRESP;
    logic                S_RLAST;
    logic                S_RVALID;
    logic                S_RREADY;

    modport slave (
        input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
        output S_AWREADY,
        input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
        output S_WREADY,
        output S_BID, S_BRESP, S_BVALID,
        input  S_BREADY,
        input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID,
        output S_ARREADY,
        output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        input  S_RREADY
    );

    modport master (
        output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
        input  S_AWREADY,
        output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
        input  S_WREADY,
        input  S_BID, S_BRESP, S_BVALID,
        output S_BREADY,
        output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID,
        input  S_ARREADY,
        input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        output S_RREADY
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational beat sequencer for one AXI burst.
//   i_idx      : word index of the current beat
//   i_burst    : AxBURST (FIXED holds, INCR/WRAP step by one word)
//   i_cnt      : zero-based number of the current beat
//   i_len      : AxLEN (beats - 1)
//   o_next_idx : word index of the following beat (wraps modulo depth)
//   o_last     : current beat is the final one of the burst
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic [1:0]       i_burst,
    input  logic [7:0]       i_cnt,
    input  logic [7:0]       i_len,
    output logic [IDX_W-1:0] o_next_idx,
    output logic             o_last
);

    // WRAP is treated as plain increment; the index already wraps at the
    // memory depth, which is the only wrap boundary this tile honours.
    always_comb begin
        o_next_idx = i_idx + IDX_W'(1);
        case (i_burst)
            BURST_FIXED: o_next_idx = i_idx;
            BURST_INCR,
            BURST_WRAP:  o_next_idx = i_idx + IDX_W'(1);
            default:     o_next_idx = i_idx + IDX_W'(1);
        endcase
    end

    assign o_last = (i_cnt == i_len);

endmodule

// File: rtl/axi_burst_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_burst_mem_slave
// AXI4 memory tile: serves FIXED/INCR/WRAP bursts (up to 256 beats) into a
// local word-addressed memory, echoing request IDs on B and R.
//   ACLK    : clock
//   ARESETn : asynchronous active-low reset (memory contents survive it)
//   s_axi   : AXI4 slave port (axi_burst_mem_slave_if.slave)
// Optional feature: define AXI_MEM_RANGE_CHECK_EN to reject addresses outside
// [BASE_ADDR, BASE_ADDR+MEM_BYTES) with DECERR (writes dropped, reads zero).
// Without it, out-of-range addresses alias onto the memory by index wrap.
// -----------------------------------------------------------------------------
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                MEM_BYTES = 8192,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_burst_mem_slave_if.slave  s_axi
);

    localparam int DEPTH     = MEM_BYTES / 8;
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int NUM_LANES = DATA_W / 8;

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0] w_aw_off;
    logic [ADDR_W-1:0] w_ar_off;
    logic [IDX_W-1:0]  w_aw_idx;
    logic [IDX_W-1:0]  w_ar_idx;
    logic              w_aw_bad;
    logic              w_ar_bad;
    logic              w_unused;

    assign w_aw_off = s_axi.S_AWADDR - BASE_ADDR;
    assign w_ar_off = s_axi.S_ARADDR - BASE_ADDR;
    assign w_aw_idx = w_aw_off[IDX_W+2:3];
    assign w_ar_idx = w_ar_off[IDX_W+2:3];

`ifdef AXI_MEM_RANGE_CHECK_EN
    // Unsigned offset: an address below BASE_ADDR wraps to a huge value, so a
    // single compare covers both ends of the window.
    assign w_aw_bad = (w_aw_off >= ADDR_W'(MEM_BYTES));
    assign w_ar_bad = (w_ar_off >= ADDR_W'(MEM_BYTES));
`else
    assign w_aw_bad = 1'b0;
    assign w_ar_bad = 1'b0;
`endif

    // SIZE is ignored (every beat is full width); byte offset bits unused.
    assign w_unused = ^{s_axi.S_AWSIZE, s_axi.S_ARSIZE, w_aw_off, w_ar_off};

    // Holds both READYs low while reset is asserted and for the first edge after.
    logic r_live;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    // ---------------- write channel ----------------
    wr_state_t         r_wstate;
    logic [ID_W-1:0]   r_wr_id;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [7:0]        r_wr_len;
    logic [1:0]        r_wr_burst;
    logic [7:0]        r_wr_cnt;
    logic              r_wr_err;
    logic              r_wr_dec;
    logic              r_bvalid;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_bresp;
    logic [IDX_W-1:0]  w_wr_next_idx;
    logic              w_wr_last;
    logic              w_awready;
    logic              w_wr_en;

    axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wr_gen (
        .i_idx      (r_wr_idx),
        .i_burst    (r_wr_burst),
        .i_cnt      (r_wr_cnt),
        .i_len      (r_wr_len),
        .o_next_idx (w_wr_next_idx),
        .o_last     (w_wr_last)
    );

    assign w_awready = (r_wstate == W_IDLE) && r_live;
    assign w_wr_en   = (r_wstate == W_DATA) && s_axi.S_WVALID && !r_wr_dec;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate   <= W_IDLE;
            r_wr_id    <= '0;
            r_wr_idx   <= '0;
            r_wr_len   <= '0;
            r_wr_burst <= BURST_INCR;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
            r_wr_dec   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (s_axi.S_AWVALID && w_awready) begin
                        r_wr_id    <= s_axi.S_AWID;
                        r_wr_idx   <= w_aw_idx;
                        r_wr_len   <= s_axi.S_AWLEN;
                        r_wr_burst <= s_axi.S_AWBURST;
                        r_wr_cnt   <= '0;
                        r_wr_err   <= 1'b0;
                        r_wr_dec   <= w_aw_bad;
                        r_wstate   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi.S_WVALID) begin
                        if (w_wr_last) begin
                            // Burst length is set by LEN; a missing WLAST here
                            // only colours the response.
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wr_id;
                            if (r_wr_dec)
                                r_bresp <= RESP_DECERR;
                            else if (r_wr_err || !s_axi.S_WLAST)
                                r_bresp <= RESP_SLVERR;
                            else
                                r_bresp <= RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            if (s_axi.S_WLAST) r_wr_err <= 1'b1;
                            r_wr_cnt <= r_wr_cnt + 8'd1;
                            r_wr_idx <= w_wr_next_idx;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign s_axi.S_AWREADY = w_awready;
    assign s_axi.S_WREADY  = (r_wstate == W_DATA);
    assign s_axi.S_BVALID  = r_bvalid;
    assign s_axi.S_BID     = r_bid;
    assign s_axi.S_BRESP   = r_bresp;

    // ---------------- read channel ----------------
    rd_state_t         r_rstate;
    logic [ID_W-1:0]   r_rid;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [7:0]        r_rd_len;
    logic [1:0]        r_rd_burst;
    logic [7:0]        r_rd_cnt;
    logic              r_rd_dec;
    logic              r_rvalid;
    logic              r_rlast;
    logic [1:0]        r_rresp;
    logic [IDX_W-1:0]  w_rd_next_idx;
    logic              w_rd_last;
    logic              w_arready;
    logic              w_ar_hs;
    logic              w_rd_load;
    logic [IDX_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0] w_rd_word;

    axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rd_gen (
        .i_idx      (r_rd_idx),
        .i_burst    (r_rd_burst),
        .i_cnt      (r_rd_cnt),
        .i_len      (r_rd_len),
        .o_next_idx (w_rd_next_idx),
        .o_last     (w_rd_last)
    );

    assign w_arready = (r_rstate == R_IDLE) && r_live;
    assign w_ar_hs   = s_axi.S_ARVALID && w_arready;
    // The memory read is fetched on the edge that accepts the previous beat
    // (or the address), so the next beat is on the bus one cycle later.
    assign w_rd_load = w_ar_hs ||
                       ((r_rstate == R_DATA) && s_axi.S_RREADY && !w_rd_last);
    assign w_rd_addr = (r_rstate == R_IDLE) ? w_ar_idx : w_rd_next_idx;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate   <= R_IDLE;
            r_rid      <= '0;
            r_rd_idx   <= '0;
            r_rd_len   <= '0;
            r_rd_burst <= BURST_INCR;
            r_rd_cnt   <= '0;
            r_rd_dec   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid      <= s_axi.S_ARID;
                        r_rd_idx   <= w_ar_idx;
                        r_rd_len   <= s_axi.S_ARLEN;
                        r_rd_burst <= s_axi.S_ARBURST;
                        r_rd_cnt   <= '0;
                        r_rd_dec   <= w_ar_bad;
                        r_rresp    <= w_ar_bad ? RESP_DECERR : RESP_OKAY;
                        r_rvalid   <= 1'b1;
                        r_rlast    <= (s_axi.S_ARLEN == 8'd0);
                        r_rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_RREADY) begin
                        if (w_rd_last) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 8'd1;
                            r_rd_idx <= w_rd_next_idx;
                            r_rlast  <= ((r_rd_cnt + 8'd1) == r_rd_len);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_ARREADY = w_arready;
    assign s_axi.S_RVALID  = r_rvalid;
    assign s_axi.S_RID     = r_rid;
    assign s_axi.S_RLAST   = r_rlast;
    assign s_axi.S_RRESP   = r_rresp;
    assign s_axi.S_RDATA   = r_rd_dec ? '0 : w_rd_word;

    // ---------------- memory: one byte-wide array per lane ----------------
    // Per-lane arrays give byte-enable writes with a plain write port each;
    // a read and write of the same word on one edge returns the old value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge ACLK) begin
                if (w_wr_en && s_axi.S_WSTRB[gi])
                    r_mem[r_wr_idx] <= s_axi.S_WDATA[gi*8 +: 8];
            end

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn)       r_q <= '0;
                else if (w_rd_load) r_q <= r_mem[w_rd_addr];
            end

            assign w_rd_word[gi*8 +: 8] = r_q;
        end
    endgenerate

endmodule
